// File: rtl/irq_ctrl_pkg.sv
// Shared types and limits for the interrupt controller slice.
// Used by irq_sync and irq_ctrl.
package irq_ctrl_pkg;

    localparam int IRQ_MAX  = 8;
    localparam int IRQ_ID_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// Part of irq_ctrl.
module irq_sync
    import irq_ctrl_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority external interrupt controller with REQ/SERVICE handshake.
// IRQ_EDGE_EN selects edge-captured pending bits; default is level mode.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_IRQ       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_IRQ-1:0]    irq_in,
    input  logic                mask_we,
    input  logic [N_IRQ-1:0]    mask_wdata,
    input  logic                ExtIAck,
    input  logic                eret,
    output logic                ExtIRQ,
    output logic [IRQ_ID_W-1:0] IrqId,
    output logic [N_IRQ-1:0]    pending,
    output logic [N_IRQ-1:0]    mask
);

    irq_state_e state;
    irq_state_e state_nxt;

    logic [N_IRQ-1:0]    irq_s;
    logic [N_IRQ-1:0]    active;
    logic [IRQ_MAX-1:0]  active_w;
    logic [IRQ_ID_W-1:0] sel;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
        irq_sync #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (irq_in[i]),
            .q     (irq_s[i])
        );
    end

`ifdef IRQ_EDGE_EN
    logic [N_IRQ-1:0]   irq_hist;
    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   ack_clr;
    logic [SYNC_STAGES:0] warm;

    // Edges are ignored until the synchronizer has refilled after reset,
    // so a line already high at reset release is not taken as an event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_hist <= '0;
            warm     <= '0;
        end else begin
            irq_hist <= irq_s;
            warm     <= {warm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign rise = warm[SYNC_STAGES] ? (irq_s & ~irq_hist) : '0;

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (state == REQ && ExtIAck && IrqId == IRQ_ID_W'(i)) begin
                ack_clr[i] = 1'b1;
            end
        end
    end

    // A new edge on the acknowledged source wins over its clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~ack_clr) | rise;
        end
    end
`else
    assign pending = irq_s;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask <= '0;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end

    assign active   = pending & mask;
    assign active_w = IRQ_MAX'(active);

    always_comb begin
        sel = '0;
        for (int i = IRQ_MAX - 1; i >= 0; i--) begin
            if (active_w[i]) begin
                sel = IRQ_ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|active) state_nxt = REQ;
            REQ:     if (ExtIAck) state_nxt = SERVICE;
            SERVICE: if (eret)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IrqId <= '0;
        end else if (state == IDLE && |active) begin
            IrqId <= sel;
        end
    end

    always_comb begin
        ExtIRQ = 1'b0;
        if (state == REQ) begin
            ExtIRQ = 1'b1;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (level or edge build).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       ExtIAck;
    logic       eret;
    logic       ExtIRQ;
    logic [2:0] IrqId;
    logic [3:0] pending;
    logic [3:0] mask;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    irq_ctrl #(
        .N_IRQ       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ExtIAck    (ExtIAck),
        .eret       (eret),
        .ExtIRQ     (ExtIRQ),
        .IrqId      (IrqId),
        .pending    (pending),
        .mask       (mask)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_mask(input logic [3:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        ExtIAck = 1'b1;
        tick();
        ExtIAck = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    initial begin
        irq_in     = 4'b0000;
        mask_we    = 1'b0;
        mask_wdata = 4'b0000;
        ExtIAck    = 1'b0;
        eret       = 1'b0;
`ifdef IRQ_EDGE_EN
        irq_in     = 4'b0001;
`endif
        tick(2);
        check("rst_irq",  ExtIRQ,  0);
        check("rst_id",   IrqId,   0);
        check("rst_pend", pending, 0);
        check("rst_mask", mask,    0);
        reset = 1'b1;

`ifdef IRQ_EDGE_EN
        wr_mask(4'b1111);
        tick(5);
        check("no_edge_at_release", pending, 4'b0000);
        check("no_req_at_release",  ExtIRQ,  0);
        irq_in = 4'b0000;
        tick(3);
        check("mask_wr", mask, 4'b1111);

        irq_in = 4'b0100; tick(); irq_in = 4'b0000; tick(2);
        check("p2_captured", pending, 4'b0100);
        check("p2_no_req",   ExtIRQ,  0);
        tick();
        check("p2_req", ExtIRQ, 1);
        check("p2_id",  IrqId,  2);
        pulse_ack();
        check("p2_ack_irq", ExtIRQ,  0);
        check("p2_ack_clr", pending, 4'b0000);
        pulse_eret();

        irq_in = 4'b1010; tick(); irq_in = 4'b0000; tick(3);
        check("pri_req", ExtIRQ, 1);
        check("pri_id1", IrqId,  1);
        pulse_ack();
        check("pri_left", pending, 4'b1000);
        pulse_eret();
        check("pri_eret_idle", ExtIRQ, 0);
        tick();
        check("pri_req3", ExtIRQ, 1);
        check("pri_id3",  IrqId,  3);

        irq_in = 4'b0001; tick(); irq_in = 4'b0000; tick(2);
        check("frozen_pend", pending, 4'b1001);
        check("frozen_id",   IrqId,   3);
        wr_mask(4'b0111);
        check("no_withdraw", ExtIRQ, 1);
        pulse_ack();
        check("ack_only_id", pending, 4'b0001);
        pulse_eret();
        tick();
        check("next_id0", IrqId, 0);
        pulse_ack();
        pulse_eret();

        wr_mask(4'b0000);
        irq_in = 4'b0001; tick(); irq_in = 4'b0000; tick(2);
        check("masked_pend", pending, 4'b0001);
        tick(2);
        check("masked_noreq", ExtIRQ, 0);
        wr_mask(4'b0001);
        check("unmask_mask", mask,   4'b0001);
        check("unmask_wait", ExtIRQ, 0);
        tick();
        check("unmask_req", ExtIRQ, 1);
        check("unmask_id",  IrqId,  0);

        irq_in = 4'b0001; tick(); irq_in = 4'b0000; tick();
        ExtIAck = 1'b1; tick(); ExtIAck = 1'b0;
        check("set_wins",     pending, 4'b0001);
        check("set_wins_svc", ExtIRQ,  0);
        pulse_ack();
        check("svc_ack_ign",  pending, 4'b0001);
        tick(2);
        check("svc_hold", ExtIRQ, 0);
        pulse_eret();
        check("svc_eret_idle", ExtIRQ, 0);
        tick();
        check("svc_rereq", ExtIRQ, 1);
        check("svc_reid",  IrqId,  0);
        pulse_ack();
        pulse_eret();

        wr_mask(4'b1111);
        irq_in = 4'b1000; tick(); irq_in = 4'b0000; tick(3);
        check("req3_id", IrqId, 3);
        pulse_eret();
        check("eret_ign_req", ExtIRQ, 1);
`else
        wr_mask(4'b1111);
        check("mask_wr", mask, 4'b1111);

        irq_in = 4'b0100; tick(2);
        check("lv_pend2",  pending, 4'b0100);
        check("lv_no_req", ExtIRQ,  0);
        tick();
        check("lv_req", ExtIRQ, 1);
        check("lv_id2", IrqId,  2);

        irq_in = 4'b0101; tick(2);
        check("lv_pend",   pending, 4'b0101);
        check("lv_frozen", IrqId,   2);
        wr_mask(4'b1011);
        check("lv_no_withdraw", ExtIRQ, 1);
        pulse_ack();
        check("lv_ack_irq",   ExtIRQ,  0);
        check("lv_ack_keeps", pending, 4'b0101);

        irq_in = 4'b0010; tick(2);
        check("lv_pend1",  pending, 4'b0010);
        check("lv_svc_lo", ExtIRQ,  0);
        pulse_eret();
        check("lv_eret_idle", ExtIRQ, 0);
        tick();
        check("lv_req1", ExtIRQ, 1);
        check("lv_id1",  IrqId,  1);
        pulse_ack();
        pulse_eret();
        tick();
        check("lv_reassert", ExtIRQ, 1);
        check("lv_reid1",    IrqId,  1);
        pulse_ack();
        irq_in = 4'b0000; tick(2);
        check("lv_dropped", pending, 4'b0000);
        pulse_eret();
        tick(2);
        check("lv_no_more", ExtIRQ, 0);

        irq_in = 4'b1000; tick(3);
        check("req3_id", IrqId, 3);
        pulse_eret();
        check("eret_ign_req", ExtIRQ, 1);
`endif

        reset = 1'b0;
        #1;
        check("mid_rst_irq",  ExtIRQ,  0);
        check("mid_rst_id",   IrqId,   0);
        check("mid_rst_pend", pending, 0);
        check("mid_rst_mask", mask,    0);
        irq_in = 4'b0000;
        tick(2);
        reset = 1'b1;
        tick(4);
        check("post_rst_idle", ExtIRQ, 0);

        wr_mask(4'b1111);
        irq_in = 4'b0010;
`ifdef IRQ_EDGE_EN
        tick(); irq_in = 4'b0000; tick(3);
`else
        tick(3);
`endif
        check("post_rst_req", ExtIRQ, 1);
        check("post_rst_id",  IrqId,  1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
